// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
   localparam logic [7:0]  LOADER_HDR           = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN_HI  = 3'd1,
      ST_LEN_LO  = 3'd2,
      ST_DATA_HI = 3'd3,
      ST_DATA_LO = 3'd4,
      ST_CHECK   = 3'd5,
      ST_ERROR   = 3'd6
   } loader_state_t;

   // A load is in flight from the length bytes through the checksum byte.
   function automatic logic state_is_busy(input loader_state_t s);
      return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
             (s == ST_DATA_LO) || (s == ST_CHECK);
   endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid
// pulse in the stop-bit centre cycle with frame_err flagging a low stop bit.
module uart_rx
   import prog_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] byte_out,
   output logic       valid,
   output logic       frame_err
);

   localparam int unsigned     CNT_W   = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   logic             r_sync1, r_sync2, r_prev;
   logic [1:0]       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_bit, w_bit_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic             r_valid, w_valid_nxt;
   logic             r_ferr, w_ferr_nxt;
   logic             w_fall;

   assign w_fall    = r_prev & ~r_sync2;
   assign byte_out  = r_shift;
   assign valid     = r_valid;
   assign frame_err = r_ferr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
         r_state <= RX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
      end
   end

   // Start is re-checked at half a bit so short low glitches are dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      case (r_state)
         RX_IDLE: begin
            w_cnt_nxt = '0;
            if (w_fall) w_state_nxt = RX_START;
         end
         RX_START: begin
            if (r_cnt == HALF_M1) begin
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_state_nxt = r_sync2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {r_sync2, r_shift[7:1]};
               w_bit_nxt   = r_bit + 3'd1;
               if (r_bit == 3'd7) w_state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (r_cnt == FULL_M1) begin
               w_cnt_nxt   = '0;
               w_valid_nxt = 1'b1;
               w_ferr_nxt  = ~r_sync2;
               w_state_nxt = RX_IDLE;
            end
         end
         default: w_state_nxt = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/prog_loader.sv
// Receives a framed program image over UART and writes it into instruction
// memory, holding the CPU in reset until the image checksum verifies.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned TIMEOUT_CLKS = 500000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic [ADDR_W-1:0] im_addr,
   output logic [15:0]       im_wdata,
   output logic              im_we,
   output logic              cpu_rst,
   output logic              busy,
   output logic              err
);

   localparam int unsigned IDX_W   = ADDR_W + 1;
   localparam int unsigned TMR_W   = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

   logic [7:0]        w_byte;
   logic              w_valid, w_ferr;
   loader_state_t     r_state, w_state_nxt;
   logic [7:0]        r_len_hi, w_len_hi_nxt, r_hi, w_hi_nxt, r_xor, w_xor_nxt;
   logic [IDX_W-1:0]  r_len, w_len_nxt, r_idx, w_idx_nxt, w_idx_inc;
   logic [TMR_W-1:0]  r_timer, w_timer_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [15:0]       r_wdata, w_wdata_nxt;
   logic              r_we, w_we_nxt;
   logic              r_cpu_rst, w_cpu_rst_nxt, r_busy, w_busy_nxt, r_err, w_err_nxt;
   logic [15:0]       w_len16;
   logic              w_len_ok, w_busy_st, w_timeout;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .byte_out  (w_byte),
      .valid     (w_valid),
      .frame_err (w_ferr)
   );

   assign w_len16   = {r_len_hi, w_byte};
   assign w_len_ok  = (w_len16 != 16'd0) && ({1'b0, w_len16} <= MAX_LEN);
   assign w_idx_inc = r_idx + IDX_W'(1);
   assign w_busy_st = state_is_busy(r_state);
   assign w_timeout = w_busy_st && ((r_timer + TMR_W'(1)) == TMR_W'(TIMEOUT_CLKS));

   assign im_addr  = r_addr;
   assign im_wdata = r_wdata;
   assign im_we    = r_we;
   assign cpu_rst  = r_cpu_rst;
   assign busy     = r_busy;
   assign err      = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_len_hi  <= '0;
         r_hi      <= '0;
         r_xor     <= '0;
         r_len     <= '0;
         r_idx     <= '0;
         r_timer   <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_we      <= 1'b0;
         r_cpu_rst <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_len_hi  <= w_len_hi_nxt;
         r_hi      <= w_hi_nxt;
         r_xor     <= w_xor_nxt;
         r_len     <= w_len_nxt;
         r_idx     <= w_idx_nxt;
         r_timer   <= w_timer_nxt;
         r_addr    <= w_addr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_we      <= w_we_nxt;
         r_cpu_rst <= w_cpu_rst_nxt;
         r_busy    <= w_busy_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // Timeout is evaluated before the received byte so it wins a tie.
   always_comb begin
      w_state_nxt  = r_state;
      w_len_hi_nxt = r_len_hi;
      w_hi_nxt     = r_hi;
      w_xor_nxt    = r_xor;
      w_len_nxt    = r_len;
      w_idx_nxt    = r_idx;
      w_timer_nxt  = r_timer + TMR_W'(1);
      w_addr_nxt   = r_addr;
      w_wdata_nxt  = r_wdata;
      w_we_nxt     = 1'b0;
      w_err_nxt    = r_err;
      if (w_timeout) begin
         w_state_nxt = ST_ERROR;
      end else if (w_valid && w_ferr) begin
         if (w_busy_st) w_state_nxt = ST_ERROR;
      end else if (w_valid) begin
         w_timer_nxt = TMR_W'(1);
         case (r_state)
            ST_IDLE, ST_ERROR: begin
               if (w_byte == LOADER_HDR) begin
                  w_state_nxt = ST_LEN_HI;
                  w_idx_nxt   = '0;
                  w_xor_nxt   = '0;
                  w_err_nxt   = 1'b0;
               end
            end
            ST_LEN_HI: begin
               w_len_hi_nxt = w_byte;
               w_state_nxt  = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               w_len_nxt   = IDX_W'(w_len16);
               w_state_nxt = w_len_ok ? ST_DATA_HI : ST_ERROR;
            end
            ST_DATA_HI: begin
               w_hi_nxt    = w_byte;
               w_xor_nxt   = r_xor ^ w_byte;
               w_state_nxt = ST_DATA_LO;
            end
            ST_DATA_LO: begin
               w_xor_nxt   = r_xor ^ w_byte;
               w_addr_nxt  = r_idx[ADDR_W-1:0];
               w_wdata_nxt = {r_hi, w_byte};
               w_we_nxt    = 1'b1;
               w_idx_nxt   = w_idx_inc;
               w_state_nxt = (w_idx_inc < r_len) ? ST_DATA_HI : ST_CHECK;
            end
            ST_CHECK: w_state_nxt = (w_byte == r_xor) ? ST_IDLE : ST_ERROR;
            default:  w_state_nxt = ST_ERROR;
         endcase
      end
      if (!state_is_busy(w_state_nxt)) w_timer_nxt = '0;
      if (w_state_nxt == ST_ERROR) w_err_nxt = 1'b1;
      w_cpu_rst_nxt = (w_state_nxt != ST_IDLE);
      w_busy_nxt    = state_is_busy(w_state_nxt);
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader sitting directly upstream of the CPU's instruction memory. It receives a framed program image over a UART RX line and writes it word-by-word into the instruction memory write port (`addr`/`wdata`/`we`). It holds the CPU core in reset while a load is in progress and releases it on a verified image, so execution restarts from PC 0.

## Interface

Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200).
- `ADDR_W`, 10: instruction memory address width.
- `TIMEOUT_CLKS`, 500000: idle-line limit between bytes once a load has started.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `rx`, in, 1: UART RX line, idle high, asynchronous to `clk`.
- `im_addr`, out, ADDR_W: instruction memory write address.
- `im_wdata`, out, 16: instruction word.
- `im_we`, out, 1: one-cycle write strobe.
- `cpu_rst`, out, 1: reset request to the CPU core. It is ORed with the top-level `RST` outside this block.
- `busy`, out, 1: load in progress.
- `err`, out, 1: sticky error flag. It is cleared by `rst` or by a new header.

## Operation

- Frame format: `0xA5` header, then LEN_HI, LEN_LO (word count N), then N words sent high byte first, then CHK = XOR of all 2N data bytes.
- Valid N is 1..2^ADDR_W. Any other N goes to ERROR with no write.
- States:
  - IDLE: non-`0xA5` bytes are ignored.
  - LEN_HI, LEN_LO.
  - DATA_HI: latch the high byte.
  - DATA_LO: assemble the word, pulse `im_we`, increment the index.
  - CHECK.
  - ERROR.
- Transitions:
  - IDLE→LEN_HI on `0xA5`. This also clears `err`, the index, and the XOR accumulator.
  - LEN_LO→DATA_HI if N is valid, else ERROR.
  - DATA_LO→DATA_HI while index < N, else CHECK.
  - CHECK→IDLE if CHK matches, else ERROR.
  - ERROR→LEN_HI on `0xA5`. Other bytes are ignored.
- Framing error (stop bit sampled 0) in any state other than IDLE/ERROR goes to ERROR.
- Timeout: a counter is reloaded on every received byte. If it reaches TIMEOUT_CLKS in LEN_HI..CHECK, the block goes to ERROR.
- Outputs by state:
  - `cpu_rst` = 1 in LEN_HI..CHECK and in ERROR; 0 in IDLE.
  - `busy` = 1 in LEN_HI..CHECK.
  - `err` = 1 in ERROR and stays set in IDLE until the next header.
- Words already written before an error stay in memory. The CPU stays in reset while in ERROR.
- Index width is ADDR_W+1 so N = 2^ADDR_W is representable. Address wrap-around cannot occur.

## Timing

- Reset values: state IDLE, `im_addr`=0, `im_wdata`=0, `im_we`=0, `cpu_rst`=0, `busy`=0, `err`=0, timeout counter 0.
- `rx` passes through a 2-flop synchronizer, giving 2 cycles of latency.
- Start bit:
  - Detected on a synchronized falling edge and re-checked low at CLKS_PER_BIT/2.
  - If the line is high again at that point, it is a glitch and the receiver returns to idle.
- Data bits are sampled at bit centres, LSB first. The stop bit is sampled at its centre.
- The byte-valid pulse is 1 cycle, asserted in the stop-bit centre cycle.
- `im_we`, `im_addr` and `im_wdata` are registered and asserted the cycle after the LO byte's valid pulse, for exactly 1 cycle.
- `cpu_rst` rises the cycle after the header byte's valid pulse. It falls the cycle after a matching CHK's valid pulse.
- `rst` asserted mid-load returns everything to reset values on the next edge, including the receiver.
- A byte arriving in the same cycle the timeout fires: the timeout wins.

## Structure

- Shared package: `loader_state_t` enum, the `LOADER_HDR = 8'hA5` constant, and the default baud constant.
- Sub-module `uart_rx`:
  - Contains the synchronizer, baud counter, bit counter and shift register.
  - Outputs `byte_out[7:0]`, `valid`, `frame_err`.
  - Parameter CLKS_PER_BIT.
- The FSM, word assembly, XOR accumulator and timeout live in `prog_loader`.
- The top level muxes the instruction memory `addr`/`wdata`/`we` between `prog_loader` and the fixed read path. `pc_out` drives the address when `im_we`=0.

## Test plan

- **Good load:** bench uses CLKS_PER_BIT=8 and sends A5 00 02 12 34 AB CD, CHK=0x12^0x34^0xAB^0xCD=0x40.
  - Required: writes (0,0x1234) and (1,0xABCD), one cycle each.
  - `cpu_rst` is high from the header until the cycle after CHK, then low; `err`=0.
- **Bad checksum:** same frame with CHK=0x41.
  - Both writes occur; the block ends in ERROR with `err`=1 and `cpu_rst`=1.
  - A following good frame clears `err` and ends in IDLE.
- **Invalid length:**
  - A5 00 00 → ERROR, no `im_we`.
  - A5 04 01 with ADDR_W=10 → ERROR, no `im_we`.
- **Framing error:** stop bit driven 0 during DATA_LO → ERROR; no write for that word.
- **Timeout:** TIMEOUT_CLKS=100; send A5 00 01 12 and then stop.
  - Required: ERROR exactly 100 cycles after the last valid pulse; `err`=1.
- **Reset and noise:**
  - `rst` pulsed mid-DATA → all outputs at reset values next cycle.
  - A 3-cycle low glitch on `rx` in IDLE produces no byte.
